// File: rtl/br_pkg.sv
// Shared types for the branch-update scheduler: the queued
// resolution record and the issue FSM states.
package br_pkg;

    localparam int PC_W = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
        logic            jump;
    } br_update_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_REDIRECT
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at ptr,
// pointer moves past the winner only when a grant is made.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] ptr_next;
    logic             found;
    int               idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        if (int'(win) + 1 >= NUM_REQ) ptr_next = '0;
        else ptr_next = win + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (found) ptr <= ptr_next;
    end

endmodule

// File: rtl/br_update_sched.sv
// Queues resolved branches from the CMP units and feeds the
// predictor one check per cycle; holds mispredict redirects.
module br_update_sched
    import br_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*PC_W-1:0]    req_pc,
    input  logic [NUM_REQ*PC_W-1:0]    req_target,
    input  logic [NUM_REQ-1:0]         req_taken,
    input  logic [NUM_REQ-1:0]         req_jump,
    input  logic                       flush,
    output logic                       chk_valid,
    output logic [PC_W-1:0]            chk_pc,
    output logic [PC_W-1:0]            chk_target,
    output logic                       chk_taken,
    output logic                       chk_jump,
    input  logic                       pred_mispredicted,
    input  logic [PC_W-1:0]            pred_restart_pc,
    output logic                       redirect_valid,
    output logic [PC_W-1:0]            redirect_pc,
    input  logic                       redirect_ack,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sched_state_t   state;
    sched_state_t   state_next;
    br_update_t     mem [DEPTH];
    br_update_t     head;
    br_update_t     in_sel;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_next;
    logic           full;
    logic           push;
    logic           pop;
    logic           can_push;
    logic [NUM_REQ-1:0] grant;

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (state == ST_ISSUE) && !flush && !rst;

    // A pop in the same cycle frees the slot the push lands in.
    assign can_push = !flush && !rst && (!full || pop);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (can_push),
        .grant (grant)
    );

    assign req_ready = grant;
    assign push      = |grant;

    always_comb begin
        in_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                in_sel.pc     = req_pc[i*PC_W +: PC_W];
                in_sel.target = req_target[i*PC_W +: PC_W];
                in_sel.taken  = req_taken[i];
                in_sel.jump   = req_jump[i];
            end
        end
    end

    assign count_next = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (push) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (pred_mispredicted) state_next = ST_REDIRECT;
                else if (count_next == '0) state_next = ST_IDLE;
            end
            ST_REDIRECT: begin
                if (redirect_ack)
                    state_next = (count_next != '0) ? ST_ISSUE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state          <= ST_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state   <= state_next;
            count_q <= count_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (pop && pred_mispredicted) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= pred_restart_pc;
            end else if (state == ST_REDIRECT && redirect_ack) begin
                redirect_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_sel;
    end

    assign head       = mem[rd_ptr];
    assign chk_valid  = pop;
    assign chk_pc     = chk_valid ? head.pc : '0;
    assign chk_target = chk_valid ? head.target : '0;
    assign chk_taken  = chk_valid & head.taken;
    assign chk_jump   = chk_valid & head.jump;
    assign count      = count_q;

endmodule

// File: tb/tb_br_update_sched.sv
// Directed bench for br_update_sched: arbitration order, FIFO
// fill, mispredict redirect, flush and mid-run reset.
module tb_br_update_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_pc;
    logic [63:0] req_target;
    logic [1:0]  req_taken;
    logic [1:0]  req_jump;
    logic        flush;
    logic        chk_valid;
    logic [31:0] chk_pc;
    logic [31:0] chk_target;
    logic        chk_taken;
    logic        chk_jump;
    logic        pred_mispredicted;
    logic [31:0] pred_restart_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic [3:0]  count;

    int cmp = 0;
    int errs = 0;

    br_update_sched #(.DEPTH(8), .NUM_REQ(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_pc            (req_pc),
        .req_target        (req_target),
        .req_taken         (req_taken),
        .req_jump          (req_jump),
        .flush             (flush),
        .chk_valid         (chk_valid),
        .chk_pc            (chk_pc),
        .chk_target        (chk_target),
        .chk_taken         (chk_taken),
        .chk_jump          (chk_jump),
        .pred_mispredicted (pred_mispredicted),
        .pred_restart_pc   (pred_restart_pc),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_ack      (redirect_ack),
        .count             (count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic tk,
                           input logic jp);
        req_valid[i]             = 1'b1;
        req_pc[i*32 +: 32]       = pc;
        req_target[i*32 +: 32]   = tgt;
        req_taken[i]             = tk;
        req_jump[i]              = jp;
    endtask

    task automatic clr_req();
        req_valid  = '0;
        req_pc     = '0;
        req_target = '0;
        req_taken  = '0;
        req_jump   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        redirect_ack = 1'b0;
        pred_mispredicted = 1'b0;
        pred_restart_pc = '0;
        clr_req();
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL reset_chk_valid got %0b exp 0", chk_valid); end
        cmp++; if (count !== 4'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", count); end
        cmp++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL reset_redirect_valid got %0b exp 0", redirect_valid); end
        cmp++; if (redirect_pc !== 32'h0) begin errs++; $display("FAIL reset_redirect_pc got %h exp 0", redirect_pc); end
        cmp++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        cmp++; if (chk_pc !== 32'h0) begin errs++; $display("FAIL reset_chk_pc got %h exp 0", chk_pc); end
    endtask

    task automatic test_single();
        set_req(0, 32'h100, 32'h200, 1'b1, 1'b0);
        #1;
        cmp++; if (req_ready !== 2'b01) begin errs++; $display("FAIL single_ready got %b exp 01", req_ready); end
        cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL single_no_bypass got %0b exp 0", chk_valid); end
        cyc();
        clr_req();
        #1;
        cmp++; if (count !== 4'd1) begin errs++; $display("FAIL single_count1 got %0d exp 1", count); end
        cmp++; if (chk_valid !== 1'b1) begin errs++; $display("FAIL single_chk_valid got %0b exp 1", chk_valid); end
        cmp++; if (chk_pc !== 32'h100) begin errs++; $display("FAIL single_chk_pc got %h exp 100", chk_pc); end
        cmp++; if (chk_target !== 32'h200) begin errs++; $display("FAIL single_chk_target got %h exp 200", chk_target); end
        cmp++; if (chk_taken !== 1'b1) begin errs++; $display("FAIL single_chk_taken got %0b exp 1", chk_taken); end
        cmp++; if (chk_jump !== 1'b0) begin errs++; $display("FAIL single_chk_jump got %0b exp 0", chk_jump); end
        cyc();
        cmp++; if (count !== 4'd0) begin errs++; $display("FAIL single_count0 got %0d exp 0", count); end
        cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL single_idle got %0b exp 0", chk_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] last_pc;
        logic [1:0]  exp_rdy;
        last_pc = '0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 32'hA00 + 32'(k*4), 32'hA80, 1'b0, 1'b0);
            set_req(1, 32'hB00 + 32'(k*4), 32'hB80, 1'b1, 1'b1);
            #1;
            exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
            cmp++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_rdy); end
            if (k == 0) begin
                cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL rr_first_empty got %0b exp 0", chk_valid); end
            end else begin
                cmp++; if (chk_pc !== last_pc) begin errs++; $display("FAIL rr_chk%0d got %h exp %h", k, chk_pc, last_pc); end
                cmp++; if (count !== 4'd1) begin errs++; $display("FAIL rr_count%0d got %0d exp 1", k, count); end
            end
            last_pc = (k % 2 == 1) ? 32'hB00 + 32'(k*4) : 32'hA00 + 32'(k*4);
            cyc();
        end
        clr_req();
        #1;
        cmp++; if (chk_pc !== last_pc) begin errs++; $display("FAIL rr_last_chk got %h exp %h", chk_pc, last_pc); end
        cmp++; if (chk_jump !== 1'b1) begin errs++; $display("FAIL rr_last_jump got %0b exp 1", chk_jump); end
        cyc();
        cmp++; if (count !== 4'd0) begin errs++; $display("FAIL rr_drain got %0d exp 0", count); end
    endtask

    task automatic test_full_redirect();
        set_req(0, 32'h300, 32'h330, 1'b1, 1'b0);
        #1;
        cyc();
        set_req(0, 32'h404, 32'h0, 1'b0, 1'b0);
        pred_mispredicted = 1'b1;
        pred_restart_pc = 32'h340;
        #1;
        cmp++; if (chk_pc !== 32'h300) begin errs++; $display("FAIL mp_head got %h exp 300", chk_pc); end
        cyc();
        pred_mispredicted = 1'b0;
        pred_restart_pc = 32'h0;
        #1;
        cmp++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL mp_redirect_valid got %0b exp 1", redirect_valid); end
        cmp++; if (redirect_pc !== 32'h340) begin errs++; $display("FAIL mp_redirect_pc got %h exp 340", redirect_pc); end
        cmp++; if (count !== 4'd1) begin errs++; $display("FAIL mp_count got %0d exp 1", count); end
        for (int n = 2; n <= 8; n++) begin
            set_req(0, 32'h400 + 32'(n*4), 32'h0, 1'b0, 1'b0);
            #1;
            cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL hold_chk%0d got %0b exp 0", n, chk_valid); end
            cyc();
        end
        set_req(0, 32'h500, 32'h0, 1'b0, 1'b0);
        #1;
        cmp++; if (count !== 4'd8) begin errs++; $display("FAIL full_count got %0d exp 8", count); end
        cmp++; if (req_ready !== 2'b00) begin errs++; $display("FAIL full_ready got %b exp 00", req_ready); end
        cmp++; if (redirect_pc !== 32'h340) begin errs++; $display("FAIL full_redirect_held got %h exp 340", redirect_pc); end
        redirect_ack = 1'b1;
        cyc();
        redirect_ack = 1'b0;
        #1;
        cmp++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL ack_redirect got %0b exp 0", redirect_valid); end
        cmp++; if (chk_pc !== 32'h404) begin errs++; $display("FAIL ack_next_chk got %h exp 404", chk_pc); end
        cmp++; if (req_ready !== 2'b01) begin errs++; $display("FAIL full_pushpop_ready got %b exp 01", req_ready); end
        cyc();
        clr_req();
        #1;
        cmp++; if (count !== 4'd8) begin errs++; $display("FAIL full_pushpop_count got %0d exp 8", count); end
        cmp++; if (chk_pc !== 32'h408) begin errs++; $display("FAIL full_next_chk got %h exp 408", chk_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        set_req(0, 32'h500, 32'h0, 1'b0, 1'b0);
        #1;
        cyc();
        set_req(0, 32'h504, 32'h0, 1'b0, 1'b0);
        pred_mispredicted = 1'b1;
        pred_restart_pc = 32'h600;
        #1;
        cyc();
        pred_mispredicted = 1'b0;
        for (int n = 2; n <= 5; n++) begin
            set_req(0, 32'h500 + 32'(n*4), 32'h0, 1'b0, 1'b0);
            #1;
            cyc();
        end
        set_req(0, 32'h700, 32'h0, 1'b1, 1'b0);
        flush = 1'b1;
        redirect_ack = 1'b1;
        #1;
        cmp++; if (count !== 4'd5) begin errs++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        cmp++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL flush_pre_redirect got %0b exp 1", redirect_valid); end
        cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL flush_cycle_chk got %0b exp 0", chk_valid); end
        cyc();
        flush = 1'b0;
        redirect_ack = 1'b0;
        clr_req();
        #1;
        cmp++; if (count !== 4'd0) begin errs++; $display("FAIL flush_count got %0d exp 0", count); end
        cmp++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL flush_redirect got %0b exp 0", redirect_valid); end
        cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL flush_chk got %0b exp 0", chk_valid); end
        cyc();
        cmp++; if (count !== 4'd0) begin errs++; $display("FAIL flush_push_dropped got %0d exp 0", count); end
        cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL flush_still_idle got %0b exp 0", chk_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 32'h800, 32'h880, 1'b1, 1'b1);
        #1;
        cyc();
        set_req(0, 32'h804, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        cyc();
        rst = 1'b0;
        clr_req();
        #1;
        cmp++; if (chk_valid !== 1'b0) begin errs++; $display("FAIL rstmid_chk got %0b exp 0", chk_valid); end
        cmp++; if (count !== 4'd0) begin errs++; $display("FAIL rstmid_count got %0d exp 0", count); end
        cmp++; if (chk_pc !== 32'h0) begin errs++; $display("FAIL rstmid_chk_pc got %h exp 0", chk_pc); end
        cmp++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL rstmid_redirect got %0b exp 0", redirect_valid); end
        set_req(0, 32'h900, 32'h0, 1'b0, 1'b0);
        set_req(1, 32'h904, 32'h0, 1'b0, 1'b0);
        #1;
        cmp++; if (req_ready !== 2'b01) begin errs++; $display("FAIL rstmid_rr got %b exp 01", req_ready); end
        cyc();
        clr_req();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_redirect();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
